// File: rtl/serial_bit_feeder_if.sv
// Load port of the serial bit feeder: a parallel word with valid/ready handshake.
interface serial_bit_feeder_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;

  modport master (output data_in, output load_valid, input load_ready);
  modport slave  (input data_in, input load_valid, output load_ready);
endinterface

// File: rtl/serial_bit_feeder.sv
// Serializes parallel words one bit per clock onto x, with a one-word holding
// register so the next word can be loaded while the current one shifts out.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 0
) (
  input  logic                clock,
  input  logic                reset,
  serial_bit_feeder_if.slave  load,
  output logic                x,
  output logic                x_valid,
  output logic                word_start,
  output logic                word_done,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = 4;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP == 0) ? '0 : GAP_W'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    GAPPING = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CNT_W-1:0] bitcnt, bitcnt_n;
  logic [GAP_W-1:0] gapcnt, gapcnt_n;
  logic             xfer;
  logic             x_n, x_valid_n, word_start_n, word_done_n, busy_n;

  // State and datapath registers; outputs are registered from next-state values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      hold            <= '0;
      hold_full       <= 1'b0;
      shreg           <= '0;
      bitcnt          <= '0;
      gapcnt          <= '0;
      load.load_ready <= 1'b1;
      x               <= 1'b0;
      x_valid         <= 1'b0;
      word_start      <= 1'b0;
      word_done       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_n;
      hold            <= hold_n;
      hold_full       <= hold_full_n;
      shreg           <= shreg_n;
      bitcnt          <= bitcnt_n;
      gapcnt          <= gapcnt_n;
      load.load_ready <= ~hold_full_n;
      x               <= x_n;
      x_valid         <= x_valid_n;
      word_start      <= word_start_n;
      word_done       <= word_done_n;
      busy            <= busy_n;
    end
  end

  // Next-state, hold handshake and output decode.
  always_comb begin
    state_n     = state;
    hold_n      = hold;
    hold_full_n = hold_full;
    shreg_n     = shreg;
    bitcnt_n    = bitcnt;
    gapcnt_n    = gapcnt;
    xfer        = 1'b0;

    case (state)
      IDLE: begin
        if (hold_full) xfer = 1'b1;
      end
      SHIFT: begin
        shreg_n  = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        bitcnt_n = bitcnt + CNT_W'(1);
        if (bitcnt == BIT_LAST) begin
          bitcnt_n = '0;
          if (GAP != 0) begin
            state_n  = GAPPING;
            gapcnt_n = '0;
          end else if (hold_full) begin
            xfer = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      GAPPING: begin
        gapcnt_n = gapcnt + GAP_W'(1);
        if (gapcnt == GAP_LAST) begin
          gapcnt_n = '0;
          if (hold_full) xfer = 1'b1;
          else           state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // A transfer needs a full hold, so it never coincides with an accept.
    if (xfer) begin
      shreg_n     = hold;
      bitcnt_n    = '0;
      state_n     = SHIFT;
      hold_full_n = 1'b0;
    end else if (load.load_valid && !hold_full) begin
      hold_n      = load.data_in;
      hold_full_n = 1'b1;
    end

    x_valid_n    = (state_n == SHIFT);
    x_n          = x_valid_n & (MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0]);
    word_start_n = x_valid_n && (bitcnt_n == '0);
    word_done_n  = x_valid_n && (bitcnt_n == BIT_LAST);
    busy_n       = (state_n != IDLE) || hold_full_n;
  end

endmodule
